// File: rtl/calc_key_sequencer.sv
// ---------------------------------------------------------------------------
// calc_key_sequencer
//
// Keypad-to-datapath sequencer for the 8-bit calculator. It collects decimal
// digits into an operand entry register. It then drives the A/B/R load pulses,
// the add/subtract select and the input-unit/arithmetic-unit source select.
// It also reports overflow/error state for the display.
//
// Build option:
//   CALC_CHAIN_EN  When defined, an add/sub key in RES turns the result into
//                  operand A so that calculations can be chained. When it is
//                  undefined, that key is rejected.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset (same effect as clear-all key)
//   key_valid   single-cycle strobe qualifying key_code
//   key_code    0-9 digit, A add, B sub, C clear entry, D clear all, F equals
//   au_ovf      arithmetic-unit overflow/borrow, sampled in the load_r cycle
//   entry       operand being keyed (input unit)
//   load_a/b/r  single-cycle register load pulses
//   addsub      0 add, 1 subtract
//   iu_au       source select, 0 entry, 1 arithmetic-unit result
//   busy        high in every load-pulse cycle
//   key_reject  single-cycle pulse when a strobe is ignored
//   err         high while in ERR
// ---------------------------------------------------------------------------
//  state | meaning
//  ENT_A | keying operand A
//  ENT_B | keying operand B (operator already chosen)
//  EXEC  | load_b then load_r cycles, keys dropped
//  RES   | result shown, iu_au selects arithmetic unit
//  ERR   | overflow/borrow, only clear keys accepted
// ---------------------------------------------------------------------------
module calc_key_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             au_ovf,
    output logic [WIDTH-1:0] entry,
    output logic             load_a,
    output logic             load_b,
    output logic             load_r,
    output logic             addsub,
    output logic             iu_au,
    output logic             busy,
    output logic             key_reject,
    output logic             err
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CE  = 4'hC;
    localparam logic [3:0] KEY_CA  = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam logic [WIDTH+3:0] ENTRY_MAX = {4'b0000, {WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        ENT_A,
        ENT_B,
        EXEC,
        RES,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             load_r_q, load_r_d;
    logic             addsub_q, addsub_d;
    logic             iu_au_q, iu_au_d;
    logic             busy_q, busy_d;
    logic             key_reject_q, key_reject_d;
    logic             err_q, err_d;

    logic             is_digit;
    logic             is_op;
    logic [WIDTH+3:0] entry_ext;
    logic [WIDTH+3:0] digit_sum;
    logic             digit_ok;
    logic             clear_all;

    // entry*10 + d, computed four bits wider than the entry so it cannot wrap
    // before the range compare.
    always_comb begin
        is_digit  = (key_code <= 4'd9);
        is_op     = (key_code == KEY_ADD) || (key_code == KEY_SUB);
        entry_ext = {4'b0000, entry_q};
        digit_sum = (entry_ext << 3) + (entry_ext << 1) + {{WIDTH{1'b0}}, key_code};
        digit_ok  = (count_q < CW'(MAX_DIGITS)) && (digit_sum <= ENTRY_MAX);
    end

    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        count_d      = count_q;
        load_a_d     = 1'b0;
        load_b_d     = 1'b0;
        load_r_d     = 1'b0;
        addsub_d     = addsub_q;
        iu_au_d      = iu_au_q;
        key_reject_d = 1'b0;
        clear_all    = 1'b0;

        // The cycle after a load pulse: the loaded operand has been captured.
        // So clear the entry, and for A from RES also drop back to the entry source.
        if (load_a_q) begin
            entry_d = '0;
            count_d = '0;
            iu_au_d = 1'b0;
        end
        if (load_b_q) begin
            entry_d  = '0;
            count_d  = '0;
            load_r_d = 1'b1;
        end
        if (load_r_q) begin
            state_d = au_ovf ? ERR : RES;
            iu_au_d = !au_ovf;
        end

        if (key_valid) begin
            if (busy_q) begin
                key_reject_d = 1'b1;
            end else begin
                unique case (state_q)
                    ENT_A, ENT_B: begin
                        if (is_digit) begin
                            if (digit_ok) begin
                                entry_d = digit_sum[WIDTH-1:0];
                                count_d = count_q + CW'(1);
                            end else begin
                                key_reject_d = 1'b1;
                            end
                        end else if (is_op) begin
                            if (state_q == ENT_A) begin
                                addsub_d = key_code[0];
                                load_a_d = 1'b1;
                                state_d  = ENT_B;
                            end else if (count_q == '0) begin
                                addsub_d = key_code[0];
                            end else begin
                                key_reject_d = 1'b1;
                            end
                        end else if (key_code == KEY_CE) begin
                            entry_d = '0;
                            count_d = '0;
                        end else if (key_code == KEY_CA) begin
                            clear_all = 1'b1;
                        end else if (key_code == KEY_EQ && state_q == ENT_B && count_q != '0) begin
                            load_b_d = 1'b1;
                            state_d  = EXEC;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end
                    RES: begin
                        if (is_digit) begin
                            entry_d = WIDTH'(key_code);
                            count_d = CW'(1);
                            iu_au_d = 1'b0;
                            state_d = ENT_A;
                        end else if (is_op) begin
`ifdef CALC_CHAIN_EN
                            // iu_au stays 1 through the pulse so A takes the result.
                            addsub_d = key_code[0];
                            load_a_d = 1'b1;
                            state_d  = ENT_B;
`else
                            key_reject_d = 1'b1;
`endif
                        end else if (key_code == KEY_CE) begin
                            entry_d = '0;
                            count_d = '0;
                            iu_au_d = 1'b0;
                            state_d = ENT_A;
                        end else if (key_code == KEY_CA) begin
                            clear_all = 1'b1;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end
                    ERR: begin
                        if (key_code == KEY_CE || key_code == KEY_CA) begin
                            clear_all = 1'b1;
                        end else begin
                            key_reject_d = 1'b1;
                        end
                    end
                    default: begin
                        // EXEC is always busy, so a key here means the state register
                        // has been upset. Refuse the key and let the load sequence finish.
                        key_reject_d = 1'b1;
                    end
                endcase
            end
        end

        if (clear_all) begin
            state_d  = ENT_A;
            entry_d  = '0;
            count_d  = '0;
            load_a_d = 1'b0;
            load_b_d = 1'b0;
            load_r_d = 1'b0;
            addsub_d = 1'b0;
            iu_au_d  = 1'b0;
        end

        busy_d = load_a_d || load_b_d || load_r_d;
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ENT_A;
            entry_q      <= '0;
            count_q      <= '0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_r_q     <= 1'b0;
            addsub_q     <= 1'b0;
            iu_au_q      <= 1'b0;
            busy_q       <= 1'b0;
            key_reject_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            count_q      <= count_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            load_r_q     <= load_r_d;
            addsub_q     <= addsub_d;
            iu_au_q      <= iu_au_d;
            busy_q       <= busy_d;
            key_reject_q <= key_reject_d;
            err_q        <= err_d;
        end
    end

    assign entry      = entry_q;
    assign load_a     = load_a_q;
    assign load_b     = load_b_q;
    assign load_r     = load_r_q;
    assign addsub     = addsub_q;
    assign iu_au      = iu_au_q;
    assign busy       = busy_q;
    assign key_reject = key_reject_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

    localparam int WIDTH      = 8;
    localparam int MAX_DIGITS = 3;
    localparam int ENTRY_MAX  = (1 << WIDTH) - 1;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_CE  = 4'hC;
    localparam logic [3:0] K_CA  = 4'hD;
    localparam logic [3:0] K_NU  = 4'hE;
    localparam logic [3:0] K_EQ  = 4'hF;

    localparam int M_EA = 0, M_EB = 1, M_RES = 2, M_ERR = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             au_ovf;
    logic [WIDTH-1:0] entry;
    logic             load_a, load_b, load_r, addsub, iu_au, busy, key_reject, err;

    int checks = 0;
    int errors = 0;

    calc_key_sequencer #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .au_ovf(au_ovf), .entry(entry), .load_a(load_a), .load_b(load_b),
        .load_r(load_r), .addsub(addsub), .iu_au(iu_au), .busy(busy),
        .key_reject(key_reject), .err(err)
    );

    always #5 clk = ~clk;

    // Key-level reference model
    int m_state, m_ent, m_cnt, m_as, m_iu;
    int exp_rej, exp_la, exp_lb, exp_lr, exp_ent_la, exp_iu_la, exp_ent_lb, exp_as_lb;
    // Observations of the most recent press
    int obs_rej, obs_la, obs_lb, obs_lr, obs_busy, obs_ent_la, obs_iu_la, obs_ent_lb, obs_as_lb;

    task automatic model_reset();
        m_state = M_EA; m_ent = 0; m_cnt = 0; m_as = 0; m_iu = 0;
    endtask

    task automatic model_press(input logic [3:0] code, input logic ovf);
        int c;
        c = int'(code);
        exp_rej = 0; exp_la = 0; exp_lb = 0; exp_lr = 0;
        exp_ent_la = 0; exp_iu_la = 0; exp_ent_lb = 0; exp_as_lb = 0;
        case (m_state)
            M_EA, M_EB: begin
                if (c <= 9) begin
                    if (m_cnt < MAX_DIGITS && m_ent * 10 + c <= ENTRY_MAX) begin
                        m_ent = m_ent * 10 + c;
                        m_cnt++;
                    end else exp_rej = 1;
                end else if (c == 10 || c == 11) begin
                    if (m_state == M_EA) begin
                        m_as = c - 10; exp_la = 1; exp_ent_la = m_ent; exp_iu_la = m_iu;
                        m_ent = 0; m_cnt = 0; m_state = M_EB;
                    end else if (m_cnt == 0) m_as = c - 10;
                    else exp_rej = 1;
                end else if (c == 12) begin
                    m_ent = 0; m_cnt = 0;
                end else if (c == 13) begin
                    model_reset();
                end else if (c == 15 && m_state == M_EB && m_cnt > 0) begin
                    exp_lb = 1; exp_lr = 1; exp_ent_lb = m_ent; exp_as_lb = m_as;
                    m_ent = 0; m_cnt = 0;
                    m_state = ovf ? M_ERR : M_RES;
                    m_iu = ovf ? 0 : 1;
                end else exp_rej = 1;
            end
            M_RES: begin
                if (c <= 9) begin
                    m_iu = 0; m_ent = c; m_cnt = 1; m_state = M_EA;
                end else if (c == 10 || c == 11) begin
`ifdef CALC_CHAIN_EN
                    m_as = c - 10; exp_la = 1; exp_ent_la = m_ent; exp_iu_la = 1;
                    m_iu = 0; m_ent = 0; m_cnt = 0; m_state = M_EB;
`else
                    exp_rej = 1;
`endif
                end else if (c == 12) begin
                    m_ent = 0; m_cnt = 0; m_iu = 0; m_state = M_EA;
                end else if (c == 13) begin
                    model_reset();
                end else exp_rej = 1;
            end
            default: begin
                if (c == 12 || c == 13) model_reset();
                else exp_rej = 1;
            end
        endcase
    endtask

    task automatic clear_obs();
        obs_rej = 0; obs_la = 0; obs_lb = 0; obs_lr = 0; obs_busy = 0;
        obs_ent_la = -1; obs_iu_la = -1; obs_ent_lb = -1; obs_as_lb = -1;
    endtask

    task automatic observe();
        if (key_reject) obs_rej++;
        if (busy) obs_busy++;
        if (load_a) begin obs_la++; obs_ent_la = int'(entry); obs_iu_la = int'(iu_au); end
        if (load_b) begin obs_lb++; obs_ent_lb = int'(entry); obs_as_lb = int'(addsub); end
        if (load_r) obs_lr++;
    endtask

    // Present one key strobe, then watch four cycles (long enough for the
    // equals sequence to settle into RES/ERR).
    task automatic press(input logic [3:0] code, input logic ovf);
        model_press(code, ovf);
        clear_obs();
        @(negedge clk);
        key_code = code; key_valid = 1'b1; au_ovf = ovf;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            key_valid = 1'b0;
            observe();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        // reset and a digit strobe in the same cycle: reset wins, no reject
        @(negedge clk);
        reset = 1'b1; key_valid = 1'b1; key_code = 4'd5;
        @(posedge clk); #1;
        reset = 1'b0; key_valid = 1'b0;
        model_reset();
        checks++;
        if (entry !== '0 || load_a !== 1'b0 || load_b !== 1'b0 || load_r !== 1'b0 ||
            addsub !== 1'b0 || iu_au !== 1'b0 || busy !== 1'b0 || key_reject !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: entry=%0d la=%b lb=%b lr=%b as=%b iu=%b busy=%b rej=%b err=%b, required all 0",
                     entry, load_a, load_b, load_r, addsub, iu_au, busy, key_reject, err);
        end
        @(posedge clk); #1;
        checks++;
        if (key_reject !== 1'b0 || entry !== '0) begin
            errors++;
            $display("FAIL reset_vs_key: rej=%b entry=%0d, required rej=0 entry=0", key_reject, entry);
        end
    endtask

    task automatic test_basic();
        int busy_total;
        do_reset();
        busy_total = 0;
        press(4'd1, 1'b0); press(4'd2, 1'b0);
        press(K_ADD, 1'b0);
        busy_total += obs_busy;
        checks++;
        if (obs_la !== 1 || obs_ent_la !== 12 || addsub !== 1'b0) begin
            errors++;
            $display("FAIL basic_load_a: la=%0d entry=%0d as=%b, required 1 12 0", obs_la, obs_ent_la, addsub);
        end
        press(4'd3, 1'b0); press(4'd4, 1'b0);
        press(K_EQ, 1'b0);
        busy_total += obs_busy;
        checks++;
        if (obs_lb !== 1 || obs_ent_lb !== 34 || obs_lr !== 1) begin
            errors++;
            $display("FAIL basic_load_b: lb=%0d entry=%0d lr=%0d, required 1 34 1", obs_lb, obs_ent_lb, obs_lr);
        end
        checks++;
        if (iu_au !== 1'b1 || err !== 1'b0 || busy_total !== 3) begin
            errors++;
            $display("FAIL basic_res: iu=%b err=%b busy_cycles=%0d, required 1 0 3", iu_au, err, busy_total);
        end
    endtask

    task automatic test_range();
        do_reset();
        press(4'd2, 1'b0); press(4'd5, 1'b0); press(4'd5, 1'b0);
        press(4'd6, 1'b0);
        checks++;
        if (obs_rej !== 1 || entry !== 8'd255) begin
            errors++;
            $display("FAIL range_255: rej=%0d entry=%0d, required 1 255", obs_rej, entry);
        end
        press(K_CE, 1'b0);
        press(4'd2, 1'b0); press(4'd5, 1'b0);
        press(4'd6, 1'b0);
        checks++;
        if (obs_rej !== 1 || entry !== 8'd25) begin
            errors++;
            $display("FAIL range_256: rej=%0d entry=%0d, required 1 25", obs_rej, entry);
        end
        press(K_NU, 1'b0);
        checks++;
        if (obs_rej !== 1 || entry !== 8'd25) begin
            errors++;
            $display("FAIL unused_code: rej=%0d entry=%0d, required 1 25", obs_rej, entry);
        end
    endtask

    task automatic test_error();
        do_reset();
        press(4'd9, 1'b0); press(K_SUB, 1'b0); press(4'd1, 1'b0);
        press(K_EQ, 1'b1);
        checks++;
        if (err !== 1'b1 || obs_lr !== 1) begin
            errors++;
            $display("FAIL err_enter: err=%b lr=%0d, required 1 1", err, obs_lr);
        end
        press(4'd5, 1'b0);
        checks++;
        if (obs_rej !== 1 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_digit: rej=%0d err=%b, required 1 1", obs_rej, err);
        end
        press(K_EQ, 1'b0);
        checks++;
        if (obs_rej !== 1 || obs_lb !== 0) begin
            errors++;
            $display("FAIL err_equals: rej=%0d lb=%0d, required 1 0", obs_rej, obs_lb);
        end
        press(K_CE, 1'b0);
        checks++;
        if (err !== 1'b0 || entry !== '0 || addsub !== 1'b0 || obs_rej !== 0) begin
            errors++;
            $display("FAIL err_clear: err=%b entry=%0d as=%b rej=%0d, required 0 0 0 0", err, entry, addsub, obs_rej);
        end
        press(4'd7, 1'b0);
        checks++;
        if (entry !== 8'd7 || obs_rej !== 0) begin
            errors++;
            $display("FAIL err_resume: entry=%0d rej=%0d, required 7 0", entry, obs_rej);
        end
    endtask

    task automatic test_res_operator();
        do_reset();
        press(4'd4, 1'b0); press(K_ADD, 1'b0); press(4'd3, 1'b0); press(K_EQ, 1'b0);
        press(K_ADD, 1'b0);
`ifdef CALC_CHAIN_EN
        checks++;
        if (obs_la !== 1 || obs_iu_la !== 1 || obs_rej !== 0 || iu_au !== 1'b0) begin
            errors++;
            $display("FAIL res_chain: la=%0d iu_in_pulse=%0d rej=%0d iu=%b, required 1 1 0 0",
                     obs_la, obs_iu_la, obs_rej, iu_au);
        end
        press(K_SUB, 1'b0);   // ENT_B with count 0: operator replaced
        checks++;
        if (addsub !== 1'b1 || obs_rej !== 0) begin
            errors++;
            $display("FAIL chain_entb: as=%b rej=%0d, required 1 0", addsub, obs_rej);
        end
`else
        checks++;
        if (obs_la !== 0 || obs_rej !== 1 || iu_au !== 1'b1) begin
            errors++;
            $display("FAIL res_nochain: la=%0d rej=%0d iu=%b, required 0 1 1", obs_la, obs_rej, iu_au);
        end
        press(K_EQ, 1'b0);
        checks++;
        if (obs_rej !== 1 || iu_au !== 1'b1) begin
            errors++;
            $display("FAIL res_equals: rej=%0d iu=%b, required 1 1", obs_rej, iu_au);
        end
`endif
        press(4'd8, 1'b0);
        checks++;
        if (entry !== 8'd8 || iu_au !== 1'b0) begin
            errors++;
            $display("FAIL res_digit: entry=%0d iu=%b, required %0d 0", entry, iu_au, m_ent);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(4'd1, 1'b0); press(K_ADD, 1'b0); press(K_SUB, 1'b0); press(4'd2, 1'b0);
        checks++;
        if (addsub !== 1'b1) begin
            errors++;
            $display("FAIL op_replace: as=%b, required 1", addsub);
        end
        // equals, then a second equals strobe landing in the load_b cycle
        model_press(K_EQ, 1'b0);
        clear_obs();
        @(negedge clk);
        key_code = K_EQ; key_valid = 1'b1; au_ovf = 1'b0;
        @(posedge clk); #1;
        observe();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            key_valid = 1'b0;
            observe();
        end
        checks++;
        if (obs_rej !== 1 || obs_lb !== 1 || obs_lr !== 1 || obs_as_lb !== 1) begin
            errors++;
            $display("FAIL busy_drop: rej=%0d lb=%0d lr=%0d as=%0d, required 1 1 1 1",
                     obs_rej, obs_lb, obs_lr, obs_as_lb);
        end
        checks++;
        if (iu_au !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop_res: iu=%b err=%b, required 1 0", iu_au, err);
        end
    endtask

    task automatic test_reset_in_exec();
        int lr_seen;
        do_reset();
        press(4'd2, 1'b0); press(K_SUB, 1'b0); press(4'd3, 1'b0);
        @(negedge clk);
        key_code = K_EQ; key_valid = 1'b1; au_ovf = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
        checks++;
        if (load_b !== 1'b1) begin
            errors++;
            $display("FAIL exec_load_b: lb=%b, required 1", load_b);
        end
        reset = 1'b1;
        lr_seen = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        if (load_r) lr_seen++;
        checks++;
        if (entry !== '0 || load_a !== 1'b0 || load_b !== 1'b0 || addsub !== 1'b0 ||
            iu_au !== 1'b0 || busy !== 1'b0 || key_reject !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL exec_reset_vals: entry=%0d la=%b lb=%b as=%b iu=%b busy=%b rej=%b err=%b, required all 0",
                     entry, load_a, load_b, addsub, iu_au, busy, key_reject, err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (load_r) lr_seen++;
        end
        checks++;
        if (lr_seen !== 0) begin
            errors++;
            $display("FAIL exec_no_load_r: load_r_cycles=%0d, required 0", lr_seen);
        end
        press(4'd6, 1'b0);
        checks++;
        if (entry !== 8'd6 || obs_rej !== 0) begin
            errors++;
            $display("FAIL exec_ent_a: entry=%0d rej=%0d, required 6 0", entry, obs_rej);
        end
    endtask

    task automatic test_random();
        logic [3:0] code;
        logic       ovf;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 55) code = 4'($urandom_range(0, 9));
            else code = 4'($urandom_range(10, 15));
            if (code == K_CA && $urandom_range(0, 3) != 0) code = K_EQ;
            ovf = ($urandom_range(0, 3) == 0);
            press(code, ovf);
            checks++;
            if (obs_rej !== exp_rej || obs_la !== exp_la || obs_lb !== exp_lb || obs_lr !== exp_lr ||
                obs_busy !== exp_la + exp_lb + exp_lr) begin
                errors++;
                $display("FAIL rand_pulses key=%0d: rej/la/lb/lr/busy=%0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d",
                         code, obs_rej, obs_la, obs_lb, obs_lr, obs_busy,
                         exp_rej, exp_la, exp_lb, exp_lr, exp_la + exp_lb + exp_lr);
            end
            checks++;
            if ((exp_la == 1 && (obs_ent_la !== exp_ent_la || obs_iu_la !== exp_iu_la)) ||
                (exp_lb == 1 && (obs_ent_lb !== exp_ent_lb || obs_as_lb !== exp_as_lb))) begin
                errors++;
                $display("FAIL rand_load_data key=%0d: a=%0d/%0d b=%0d/%0d, required a=%0d/%0d b=%0d/%0d",
                         code, obs_ent_la, obs_iu_la, obs_ent_lb, obs_as_lb,
                         exp_ent_la, exp_iu_la, exp_ent_lb, exp_as_lb);
            end
            checks++;
            if (int'(entry) !== m_ent || int'(addsub) !== m_as || int'(iu_au) !== m_iu ||
                int'(err) !== ((m_state == M_ERR) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_state key=%0d: entry=%0d as=%b iu=%b err=%b, required %0d %0d %0d %0d",
                         code, entry, addsub, iu_au, err, m_ent, m_as, m_iu, (m_state == M_ERR) ? 1 : 0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; au_ovf = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_range();
        test_error();
        test_res_operator();
        test_back_to_back();
        test_reset_in_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
